gat_bram_loader: RTL and testbench



---
 rtl/gat_bram_loader.sv | 276 +++++++++++++++++++++++++++
 tb/tb_gat_bram_loader.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gat_bram_loader.sv
// rtl/gat_bram_loader.sv - host stream loader for GAT input BRAMs with feature readback stream
//
// Purpose:
//   Writes a 32-bit host stream into the H data, H node info and weight BRAMs
//   (in that order, at contiguous byte addresses starting at 0) and raises a
//   sticky load-done flag per memory. It then waits for gat_ready_i, reads
//   feat_count words back from the new-feature BRAM and streams them out.
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   start_i, *_count_i        job start pulse and word counts (sampled at start)
//   s_tdata/tvalid/tready     host input stream
//   *_bram_din/ena/wea/addra  BRAM write ports (byte addresses)
//   *_bram_load_done_o        sticky per-memory load complete
//   gat_ready_i               accelerator finished
//   feat_bram_addrb_o/dout_i  feature BRAM read port (RD_LAT cycles)
//   m_tdata/tvalid/tready/tlast  feature output stream
//   busy_o, done_o            job in progress / one-cycle completion pulse
module gat_bram_loader #(
  parameter int TOP_WIDTH          = 32,
  parameter int H_DATA_ADDR_W      = 18,
  parameter int NODE_INFO_ADDR_W   = 14,
  parameter int WEIGHT_ADDR_W      = 15,
  parameter int NEW_FEATURE_ADDR_W = 16,
  parameter int NEW_FEATURE_WIDTH  = 32,
  parameter int RD_LAT             = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [H_DATA_ADDR_W:0]        h_data_count_i,
  input  logic [NODE_INFO_ADDR_W:0]     node_info_count_i,
  input  logic [WEIGHT_ADDR_W:0]        wgt_count_i,
  input  logic [NEW_FEATURE_ADDR_W:0]   feat_count_i,
  input  logic [TOP_WIDTH-1:0]          s_tdata_i,
  input  logic                          s_tvalid_i,
  output logic                          s_tready_o,
  output logic [TOP_WIDTH-1:0]          h_data_bram_din_o,
  output logic                          h_data_bram_ena_o,
  output logic                          h_data_bram_wea_o,
  output logic [H_DATA_ADDR_W+1:0]      h_data_bram_addra_o,
  output logic [TOP_WIDTH-1:0]          h_node_info_bram_din_o,
  output logic                          h_node_info_bram_ena_o,
  output logic                          h_node_info_bram_wea_o,
  output logic [NODE_INFO_ADDR_W+1:0]   h_node_info_bram_addra_o,
  output logic [TOP_WIDTH-1:0]          wgt_bram_din_o,
  output logic                          wgt_bram_ena_o,
  output logic                          wgt_bram_wea_o,
  output logic [WEIGHT_ADDR_W+1:0]      wgt_bram_addra_o,
  output logic                          h_data_bram_load_done_o,
  output logic                          h_node_info_bram_load_done_o,
  output logic                          wgt_bram_load_done_o,
  input  logic                          gat_ready_i,
  output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb_o,
  input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout_i,
  output logic [NEW_FEATURE_WIDTH-1:0]  m_tdata_o,
  output logic                          m_tvalid_o,
  input  logic                          m_tready_i,
  output logic                          m_tlast_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int HW     = H_DATA_ADDR_W;
  localparam int NW     = NODE_INFO_ADDR_W;
  localparam int WW     = WEIGHT_ADDR_W;
  localparam int FW     = NEW_FEATURE_ADDR_W;
  localparam int MAX_HN = (HW > NW) ? HW : NW;
  localparam int IDX_W  = ((MAX_HN > WW) ? MAX_HN : WW) + 1;
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [FW:0]      FW_ONE  = (FW + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_H, S_LOAD_NI, S_LOAD_W, S_WAIT_GAT, S_READ, S_FIN
  } state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0] idx_q;
  logic [HW:0]      h_cnt_q;
  logic [NW:0]      ni_cnt_q;
  logic [WW:0]      w_cnt_q;
  logic [FW:0]      f_cnt_q;

  logic [TOP_WIDTH-1:0] h_din_q, ni_din_q, w_din_q;
  logic                 h_ena_q, ni_ena_q, w_ena_q;
  logic [HW+1:0]        h_addra_q;
  logic [NW+1:0]        ni_addra_q;
  logic [WW+1:0]        w_addra_q;
  logic [2:0]           ld_done_q, pend_q;

  logic [FW:0]   ridx_q, oidx_q;
  logic [FW+1:0] addrb_q;
  logic [RD_LAT-1:0] vpipe_q, vpipe_d;
  logic [NEW_FEATURE_WIDTH-1:0] fifo_q [4];
  logic [1:0] wptr_q, rptr_q;
  logic [2:0] fcnt_q;

  logic [2:0]       region, done_set;
  logic [IDX_W-1:0] cur_cnt;
  logic             in_load, accept, last_beat, skip, start_job;
  logic             issue, capture, pop;
  logic [3:0]       inflight;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start_i) state_d = S_LOAD_H;
      S_LOAD_H:   if (skip || last_beat) state_d = S_LOAD_NI;
      S_LOAD_NI:  if (skip || last_beat) state_d = S_LOAD_W;
      S_LOAD_W:   if (skip || last_beat) state_d = S_WAIT_GAT;
      S_WAIT_GAT: if (gat_ready_i) state_d = (f_cnt_q == '0) ? S_FIN : S_READ;
      S_READ:     if (pop && m_tlast_o) state_d = S_FIN;
      S_FIN:      state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output and handshake decode
  always_comb begin
    region  = 3'b000;
    cur_cnt = '0;
    case (state_q)
      S_LOAD_H:  begin region = 3'b001; cur_cnt[HW:0] = h_cnt_q;  end
      S_LOAD_NI: begin region = 3'b010; cur_cnt[NW:0] = ni_cnt_q; end
      S_LOAD_W:  begin region = 3'b100; cur_cnt[WW:0] = w_cnt_q;  end
      default:   ;
    endcase
    in_load    = |region;
    start_job  = (state_q == S_IDLE) && start_i;
    s_tready_o = in_load && (idx_q < cur_cnt);
    accept     = s_tvalid_i && s_tready_o;
    last_beat  = accept && ((idx_q + IDX_ONE) == cur_cnt);
    // An empty region still reports done, one cycle after it is entered
    skip       = in_load && (cur_cnt == '0);
    done_set   = pend_q | (skip ? region : 3'b000);

    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + 4'(vpipe_q[i]);
    // Credit rule: buffered plus in-flight words never exceed the FIFO depth
    issue = (state_q == S_READ) && (ridx_q < f_cnt_q) &&
            (({1'b0, fcnt_q} + inflight) < 4'd4);
    vpipe_d    = '0;
    vpipe_d[0] = issue;
    for (int i = 1; i < RD_LAT; i++) vpipe_d[i] = vpipe_q[i-1];
    capture = vpipe_q[RD_LAT-1];

    feat_bram_addrb_o = issue ? {ridx_q[FW-1:0], 2'b00} : addrb_q;
    m_tvalid_o = (fcnt_q != 3'd0);
    m_tdata_o  = fifo_q[rptr_q];
    m_tlast_o  = m_tvalid_o && (oidx_q == (f_cnt_q - FW_ONE));
    pop        = m_tvalid_o && m_tready_i;
    busy_o     = (state_q != S_IDLE);
    done_o     = (state_q == S_FIN);
  end

  // Datapath: write ports, indices, flags, read pipeline and FIFO control
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q      <= '0;
      h_cnt_q    <= '0;
      ni_cnt_q   <= '0;
      w_cnt_q    <= '0;
      f_cnt_q    <= '0;
      h_din_q    <= '0;
      ni_din_q   <= '0;
      w_din_q    <= '0;
      h_ena_q    <= 1'b0;
      ni_ena_q   <= 1'b0;
      w_ena_q    <= 1'b0;
      h_addra_q  <= '0;
      ni_addra_q <= '0;
      w_addra_q  <= '0;
      ld_done_q  <= '0;
      pend_q     <= '0;
      ridx_q     <= '0;
      oidx_q     <= '0;
      addrb_q    <= '0;
      vpipe_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      fcnt_q     <= '0;
    end else begin
      h_ena_q   <= 1'b0;
      ni_ena_q  <= 1'b0;
      w_ena_q   <= 1'b0;
      pend_q    <= '0;
      ld_done_q <= ld_done_q | done_set;
      if (accept) begin
        if (region[0]) begin
          h_din_q   <= s_tdata_i;
          h_ena_q   <= 1'b1;
          h_addra_q <= {idx_q[HW-1:0], 2'b00};
        end
        if (region[1]) begin
          ni_din_q   <= s_tdata_i;
          ni_ena_q   <= 1'b1;
          ni_addra_q <= {idx_q[NW-1:0], 2'b00};
        end
        if (region[2]) begin
          w_din_q   <= s_tdata_i;
          w_ena_q   <= 1'b1;
          w_addra_q <= {idx_q[WW-1:0], 2'b00};
        end
        // The flag follows the final write strobe by one cycle
        if (last_beat) begin
          idx_q  <= '0;
          pend_q <= region;
        end else begin
          idx_q <= idx_q + IDX_ONE;
        end
      end

      vpipe_q <= vpipe_d;
      if (issue) begin
        ridx_q  <= ridx_q + FW_ONE;
        addrb_q <= feat_bram_addrb_o;
      end
      if (capture) wptr_q <= wptr_q + 2'd1;
      if (pop) begin
        rptr_q <= rptr_q + 2'd1;
        oidx_q <= oidx_q + FW_ONE;
      end
      case ({capture, pop})
        2'b10:   fcnt_q <= fcnt_q + 3'd1;
        2'b01:   fcnt_q <= fcnt_q - 3'd1;
        default: ;
      endcase

      if (start_job) begin
        h_cnt_q   <= h_data_count_i;
        ni_cnt_q  <= node_info_count_i;
        w_cnt_q   <= wgt_count_i;
        f_cnt_q   <= feat_count_i;
        ld_done_q <= '0;
        pend_q    <= '0;
        idx_q     <= '0;
        ridx_q    <= '0;
        oidx_q    <= '0;
        vpipe_q   <= '0;
        wptr_q    <= '0;
        rptr_q    <= '0;
        fcnt_q    <= '0;
      end
    end
  end

  // FIFO storage needs no reset; occupancy alone decides what is valid
  always_ff @(posedge clk_i) begin
    if (capture) fifo_q[wptr_q] <= feat_bram_dout_i;
  end

  assign h_data_bram_din_o            = h_din_q;
  assign h_data_bram_ena_o            = h_ena_q;
  assign h_data_bram_wea_o            = h_ena_q;
  assign h_data_bram_addra_o          = h_addra_q;
  assign h_node_info_bram_din_o       = ni_din_q;
  assign h_node_info_bram_ena_o       = ni_ena_q;
  assign h_node_info_bram_wea_o       = ni_ena_q;
  assign h_node_info_bram_addra_o     = ni_addra_q;
  assign wgt_bram_din_o               = w_din_q;
  assign wgt_bram_ena_o               = w_ena_q;
  assign wgt_bram_wea_o               = w_ena_q;
  assign wgt_bram_addra_o             = w_addra_q;
  assign h_data_bram_load_done_o      = ld_done_q[0];
  assign h_node_info_bram_load_done_o = ld_done_q[1];
  assign wgt_bram_load_done_o         = ld_done_q[2];

endmodule

// File: tb/tb_gat_bram_loader.sv
// tb/tb_gat_bram_loader.sv - scoreboard bench for gat_bram_loader
module tb_gat_bram_loader;
  localparam int L = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start;
  logic [18:0] h_cnt;
  logic [14:0] ni_cnt;
  logic [15:0] w_cnt;
  logic [16:0] f_cnt;
  logic [31:0] s_tdata;
  logic        s_tvalid, s_tready;
  logic [31:0] h_din, ni_din, w_din;
  logic        h_ena, h_wea, ni_ena, ni_wea, w_ena, w_wea;
  logic [19:0] h_addra;
  logic [15:0] ni_addra;
  logic [16:0] w_addra;
  logic        h_done, ni_done, w_done;
  logic        gat_ready;
  logic [17:0] feat_addrb;
  logic [31:0] feat_dout;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tready, m_tlast;
  logic        busy, done;
  logic [2:0]  flags;
  assign flags = {w_done, ni_done, h_done};

  gat_bram_loader #(.RD_LAT(L)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .h_data_count_i(h_cnt), .node_info_count_i(ni_cnt),
    .wgt_count_i(w_cnt), .feat_count_i(f_cnt),
    .s_tdata_i(s_tdata), .s_tvalid_i(s_tvalid), .s_tready_o(s_tready),
    .h_data_bram_din_o(h_din), .h_data_bram_ena_o(h_ena),
    .h_data_bram_wea_o(h_wea), .h_data_bram_addra_o(h_addra),
    .h_node_info_bram_din_o(ni_din), .h_node_info_bram_ena_o(ni_ena),
    .h_node_info_bram_wea_o(ni_wea), .h_node_info_bram_addra_o(ni_addra),
    .wgt_bram_din_o(w_din), .wgt_bram_ena_o(w_ena),
    .wgt_bram_wea_o(w_wea), .wgt_bram_addra_o(w_addra),
    .h_data_bram_load_done_o(h_done), .h_node_info_bram_load_done_o(ni_done),
    .wgt_bram_load_done_o(w_done), .gat_ready_i(gat_ready),
    .feat_bram_addrb_o(feat_addrb), .feat_bram_dout_i(feat_dout),
    .m_tdata_o(m_tdata), .m_tvalid_o(m_tvalid), .m_tready_i(m_tready),
    .m_tlast_o(m_tlast), .busy_o(busy), .done_o(done)
  );

  // Feature memory: word at byte address a holds a + 1 + seed, L-cycle read
  logic [31:0] mem_seed;
  logic [17:0] ap [L];
  always @(posedge clk) begin
    ap[0] <= feat_addrb;
    for (int i = 1; i < L; i++) ap[i] <= ap[i-1];
  end
  assign feat_dout = 32'(ap[L-1]) + 32'd1 + mem_seed;

  typedef struct packed {logic [31:0] addr; logic [31:0] data;} wr_t;
  typedef struct packed {logic [31:0] data; logic last;} rd_t;
  wr_t wq0[$], wq1[$], wq2[$];
  rd_t rq[$];

  int total = 0;
  int bad = 0;
  int ni_wr_cnt, pops_in_job, done_seen, mr_mode, stall_left;
  logic [2:0] flag_chk;
  logic prev_final_hs, hs_last, job_fzero;
  logic [2:0] enas;
  rd_t e_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string name);
    logic [255:0] v;
    v = 256'({h_din, h_ena, h_wea, h_addra, ni_din, ni_ena, ni_wea, ni_addra,
              w_din, w_ena, w_wea, w_addra, flags, s_tready, feat_addrb,
              m_tvalid, m_tlast, busy, done});
    total++;
    if (v !== '0) begin
      bad++;
      $display("FAIL %s: outputs %0h want 0", name, v);
    end
  endtask

  task automatic chk_wr(input int r, input logic wea, input logic [31:0] addr,
                        input logic [31:0] data, input logic flag);
    wr_t e;
    int sz;
    sz = (r == 0) ? wq0.size() : (r == 1) ? wq1.size() : wq2.size();
    check($sformatf("wr_expected_r%0d", r), 32'(sz != 0), 32'd1);
    if (sz != 0) begin
      case (r)
        0:       e = wq0.pop_front();
        1:       e = wq1.pop_front();
        default: e = wq2.pop_front();
      endcase
      check($sformatf("wr_addr_r%0d", r), addr, e.addr);
      check($sformatf("wr_data_r%0d", r), data, e.data);
      check($sformatf("wr_wea_r%0d", r), 32'(wea), 32'd1);
      check($sformatf("flag_early_r%0d", r), 32'(flag), 32'd0);
      if (sz == 1) flag_chk[r] = 1'b1;
      if (r == 1) ni_wr_cnt++;
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a write or an output beat
  initial begin
    flag_chk = '0;
    prev_final_hs = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int r = 0; r < 3; r++)
          if (flag_chk[r]) check($sformatf("load_done_latency_r%0d", r), 32'(flags[r]), 32'd1);
        flag_chk = '0;
        enas = {w_ena, ni_ena, h_ena};
        if (|enas) check("ena_onehot", 32'($onehot(enas)), 32'd1);
        if (h_ena)  chk_wr(0, h_wea, 32'(h_addra), h_din, flags[0]);
        if (ni_ena) chk_wr(1, ni_wea, 32'(ni_addra), ni_din, flags[1]);
        if (w_ena)  chk_wr(2, w_wea, 32'(w_addra), w_din, flags[2]);
        hs_last = 1'b0;
        if (m_tvalid) begin
          check("m_tvalid_expected", 32'(rq.size() != 0), 32'd1);
          if (m_tready && rq.size() != 0) begin
            e_rd = rq.pop_front();
            check("m_tdata", m_tdata, e_rd.data);
            check("m_tlast", 32'(m_tlast), 32'(e_rd.last));
            hs_last = e_rd.last;
            pops_in_job++;
          end
        end
        if (done) begin
          check("done_timing", 32'(prev_final_hs || job_fzero), 32'd1);
          done_seen++;
        end
        prev_final_hs = hs_last;
      end
    end
  end

  // Output-side backpressure: 0 always ready, 1 random, 2 ten-cycle stall after two beats
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (mr_mode)
        0: m_tready = 1'b1;
        1: m_tready = 1'($urandom_range(0, 1));
        default:
          if (pops_in_job >= 2 && stall_left > 0) begin
            m_tready = 1'b0;
            stall_left--;
          end else m_tready = 1'b1;
      endcase
    end
  end

  task automatic run_job(input int hc, input int nc, input int wc, input int fc,
                         input int vmode, input int mmode, input int gdelay,
                         input bit seq_words, input bit abort_ni);
    logic [31:0] words[$];
    int tot, idx, cyc;
    bit hs;
    tot = hc + nc + wc;
    mem_seed = seq_words ? 32'd0 : $urandom;
    for (int i = 0; i < tot; i++) words.push_back(seq_words ? 32'h10 + i : $urandom);
    for (int i = 0; i < hc; i++) wq0.push_back({32'(4 * i), words[i]});
    for (int i = 0; i < nc; i++) wq1.push_back({32'(4 * i), words[hc + i]});
    for (int i = 0; i < wc; i++) wq2.push_back({32'(4 * i), words[hc + nc + i]});
    for (int k = 0; k < fc; k++) rq.push_back({32'(4 * k + 1) + mem_seed, k == fc - 1});
    job_fzero = (fc == 0);
    pops_in_job = 0;
    done_seen = 0;
    ni_wr_cnt = 0;
    mr_mode = mmode;
    stall_left = 10;

    @(posedge clk); #1;
    h_cnt = 19'(hc); ni_cnt = 15'(nc); w_cnt = 16'(wc); f_cnt = 17'(fc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("flags_cleared", 32'(flags), 32'd0);

    idx = 0;
    cyc = 0;
    while (idx < tot && cyc < 2000) begin
      s_tdata  = words[idx];
      s_tvalid = (vmode == 0) ? 1'b1 : (vmode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
      @(negedge clk);
      hs = s_tvalid && s_tready;
      @(posedge clk); #1;
      if (hs) idx++;
      cyc++;
      if (abort_ni && ni_wr_cnt >= 1) begin
        #2 rst = 1'b1;
        #1 check_reset("reset_mid_load_ni");
        s_tvalid = 1'b0;
        wq0.delete(); wq1.delete(); wq2.delete(); rq.delete();
        flag_chk = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        return;
      end
    end
    s_tvalid = 1'b0;
    check("load_beats", 32'(idx), 32'(tot));

    cyc = 0;
    while (flags != 3'b111 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("flags_all_set", 32'(flags), 32'd7);

    // Stray beats and a stray start while waiting for the accelerator
    s_tvalid = 1'b1;
    s_tdata  = 32'hdead_beef;
    for (int i = 0; i < gdelay; i++) begin
      start = (i == 3);
      if (i == 3) begin h_cnt = 19'd7; f_cnt = 17'd1; end
      @(negedge clk);
      check("s_tready_wait_gat", 32'(s_tready), 32'd0);
      @(posedge clk); #1;
    end
    start = 1'b0;
    s_tvalid = 1'b0;
    gat_ready = 1'b1;
    cyc = 0;
    while (done_seen == 0 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    gat_ready = 1'b0;
    check("done_seen", 32'(done_seen), 32'd1);
    @(posedge clk); #1;
    check("busy_after_done", 32'(busy), 32'd0);
    check("flags_sticky", 32'(flags), 32'd7);
    check("rd_queue_drained", 32'(rq.size()), 32'd0);
    check("wr_queues_drained", 32'(wq0.size() + wq1.size() + wq2.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    start = 1'b0; s_tvalid = 1'b0; s_tdata = '0; gat_ready = 1'b0;
    h_cnt = '0; ni_cnt = '0; w_cnt = '0; f_cnt = '0;
    mem_seed = '0; mr_mode = 0; stall_left = 0;
    pops_in_job = 0; done_seen = 0; ni_wr_cnt = 0; job_fzero = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset("reset_state");
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset("idle_after_reset");

    run_job(3, 2, 4, 5, 0, 0, 20, 1'b1, 1'b0);
    run_job(6, 1, 1, 3, 1, 0, 4, 1'b0, 1'b0);
    run_job(1, 1, 1, 8, 0, 2, 2, 1'b0, 1'b0);
    run_job(0, 2, 0, 0, 0, 0, 5, 1'b0, 1'b0);
    run_job(2, 3, 2, 4, 0, 0, 3, 1'b0, 1'b1);
    check("flags_after_abort", 32'(flags), 32'd0);
    run_job(2, 3, 2, 4, 0, 0, 3, 1'b0, 1'b0);
    for (int j = 0; j < 6; j++)
      run_job($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6),
              $urandom_range(0, 9), 2, 1, $urandom_range(0, 6), 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
